ex_muldiv: RTL
==============

# ex_muldiv

Iterative 64-bit RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register-file operands and destination index latched by ID/EX and produces a result for the EX/MEM register. Execution is multi-cycle; `busy_out` drives the hazard unit's stall. The block covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus the *W variants.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock; rising edge active.
- rst  in  1  reset; asynchronous, active-low.
- start_in  in  1  operation request, sampled only in IDLE.
- op_in  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_in  in  1  selects the *W variant: 32-bit operation with a sign-extended result.
- rs1Data_in  in  64  operand A, from ID/EX rs1Data_out.
- rs2Data_in  in  64  operand B, from ID/EX rs2Data_out.
- rd_in  in  5  destination register index.
- flush_in  in  1  abort; has priority over everything except reset.
- busy_out  out  1  operation in flight; hazard unit stalls on start_in | busy_out.
- done_out  out  1  one-cycle result-valid pulse.
- result_out  out  64  result; held until the next done_out.
- rd_out  out  5  rd captured at start, qualified by done_out.

## Operation
- Reset values: state IDLE; busy_out 0; done_out 0; result_out 0; rd_out 0; all internal registers 0.
- States and transitions:
  - IDLE: on start_in & !flush_in, capture operands, op, word and rd. Go to FIN if a special case applies, otherwise go to CALC with count = N-1.
  - CALC: perform one iteration per cycle. Go to FIN when count = 0.
  - FIN: apply sign correction and select the result. Register result_out and rd_out, pulse done_out, return to IDLE.
- N = 64 for full-width ops; N = 32 when word_in = 1.
- Word operand preparation: use the low 32 bits, sign- or zero-extended according to the signedness of the op.
- Signed handling: operate on absolute values.
  - Product is negated if the operand signs differ.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - MULHSU treats B as unsigned.
- Multiply: shift-add into a 2N-bit accumulator. MUL returns the low N bits; MULH* return the high N bits.
- Divide: restoring division, one quotient bit per cycle.
- Special cases (no CALC):
  - Divide by zero: quotient = all ones; remainder = A.
  - Signed overflow (A = most-negative, B = -1): quotient = A; remainder = 0.
- Word results: sign-extend bit 31 into bits 63:32, for all *W ops including unsigned ones.
- start_in while busy: ignored; the in-flight operation is unaffected.
- flush_in: at the next edge go to IDLE and clear busy_out. No done_out is produced, and result_out keeps its old value.
- flush_in together with start_in in IDLE: the start is dropped.
- Reset mid-operation: return to reset values immediately. No done_out is produced.

## Timing
- Start accepted at edge E0. busy_out is 1 after edges E0 through E0+N, i.e. N+1 cycles.
- done_out is 1 for exactly the one cycle after edge E0+N+1. Latency is N+1 cycles: 65 full-width, 33 word.
- Special cases: FIN is entered at E0; done_out follows edge E0+1 (latency 1).
- Back-to-back: a new start may be accepted in the cycle done_out is high.
- Throughput: one operation per N+1 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package ex_pkg holds:
  - XLEN;
  - enum muldiv_op_e with the eight funct3 codes above;
  - enum muldiv_state_e {IDLE, CALC, FIN}.
- Natural sub-module: ex_muldiv_core, an unsigned iterative engine (shift-add and restoring divide, with its counter).
- The top level handles operand preparation, special-case detection, sign fixup, word extension and the handshake.

## Test plan
- Reset: drive rst=0 mid-CALC of a MUL. Required: busy_out, done_out, result_out and rd_out all go to 0 immediately; no done_out after release.
- MUL: A=0x7, B=0xFFFFFFFFFFFFFFFD (-3), rd=5. Required: done_out 65 cycles after start; result_out 0xFFFFFFFFFFFFFFEB; rd_out 5.
- MULHU: A=B=0xFFFFFFFFFFFFFFFF. Required: result 0xFFFFFFFFFFFFFFFE.
- DIV:
  - A=-7, B=2. Required: quotient 0xFFFFFFFFFFFFFFFD (-3).
  - REM with the same operands. Required: 0xFFFFFFFFFFFFFFFF (-1).
- Special cases:
  - DIVU with B=0. Required: result all ones, done_out at latency 1.
  - DIV with A=0x8000000000000000, B=-1. Required: result 0x8000000000000000.
- DIVW: A=0x00000000_80000000, B=1, word_in=1. Required: done_out at latency 33; result 0xFFFFFFFF80000000.
- Handshake:
  - Assert start_in while busy. Required: ignored.
  - Assert flush_in at cycle 10 of a CALC. Required: IDLE next cycle, no done_out.
  - Issue a new start in the same cycle as done_out. Required: it is accepted.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared EX-stage types for the iterative RV64M mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_core
// Description : Unsigned iterative engine: shift-add multiply / restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_core #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic            word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            last
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_m;
    logic [CW-1:0]   r_cnt;
    logic            r_div;

    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rshift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign w_addend = r_lo[0] ? r_m : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_rshift = {r_hi, r_lo[XLEN-1]};
    assign w_diff   = w_rshift - {1'b0, r_m};
    assign w_ge     = ~w_diff[XLEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (load) begin
            r_cnt <= word ? CW'(HALF - 1) : CW'(XLEN - 1);
            r_div <= is_div;
            r_hi  <= '0;
            if (is_div) begin
                // Word dividend is pre-aligned so its MSB leaves first.
                r_lo <= word ? {op_a[HALF-1:0], {HALF{1'b0}}} : op_a;
                r_m  <= op_b;
            end else begin
                r_lo <= op_b;
                r_m  <= op_a;
            end
        end else if (step) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_div) begin
                r_hi <= w_ge ? w_diff[XLEN-1:0] : w_rshift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX-stage RV64M multiply/divide unit with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      op_in,
    input  logic            word_in,
    input  logic [XLEN-1:0] rs1Data_in,
    input  logic [XLEN-1:0] rs2Data_in,
    input  logic [4:0]      rd_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out
);
    import ex_pkg::*;

    localparam int HALF = XLEN / 2;

    muldiv_state_e   r_state;
    logic [2:0]      r_op;
    logic            r_word;
    logic [4:0]      r_rd;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_special;
    logic [XLEN-1:0] r_spec_res;

    logic            w_sa, w_sb, w_neg_a, w_neg_b;
    logic [XLEN-1:0] w_a, w_b, w_abs_a, w_abs_b, w_minneg;
    logic            w_div_zero, w_ovf, w_special, w_accept;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN-1:0] w_core_hi, w_core_lo;
    logic            w_core_last;
    logic [2*XLEN-1:0] w_mag, w_prod;
    logic [XLEN-1:0] w_mul_res, w_quo, w_rmd, w_raw, w_final;

    assign w_sa = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_sb = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

    assign w_a = word_in ? {{HALF{w_sa & rs1Data_in[HALF-1]}}, rs1Data_in[HALF-1:0]} : rs1Data_in;
    assign w_b = word_in ? {{HALF{w_sb & rs2Data_in[HALF-1]}}, rs2Data_in[HALF-1:0]} : rs2Data_in;

    assign w_neg_a = w_sa & w_a[XLEN-1];
    assign w_neg_b = w_sb & w_b[XLEN-1];
    assign w_abs_a = w_neg_a ? -w_a : w_a;
    assign w_abs_b = w_neg_b ? -w_b : w_b;

    // Most-negative value of the active width, already sign-extended.
    assign w_minneg   = word_in ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = op_in[2] & (w_b == '0);
    assign w_ovf      = op_in[2] & w_sa & (w_a == w_minneg) & (w_b == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_spec_res = w_div_zero ? (op_in[1] ? w_a : '1) : (op_in[1] ? '0 : w_a);

    assign w_accept = (r_state == IDLE) & start_in & ~flush_in;

    ex_muldiv_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .step   (r_state == CALC),
        .is_div (op_in[2]),
        .word   (word_in),
        .op_a   (w_abs_a),
        .op_b   (w_abs_b),
        .hi     (w_core_hi),
        .lo     (w_core_lo),
        .last   (w_core_last)
    );

    // Word products sit 32 bits up in the accumulator after 32 right shifts.
    assign w_mag  = r_word ? {{XLEN{1'b0}}, w_core_hi[HALF-1:0], w_core_lo[XLEN-1:HALF]}
                           : {w_core_hi, w_core_lo};
    assign w_prod = (r_neg_a ^ r_neg_b) ? -w_mag : w_mag;
    assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                     : (r_word ? {{HALF{1'b0}}, w_prod[XLEN-1:HALF]} : w_prod[2*XLEN-1:XLEN]);

    assign w_quo   = (r_neg_a ^ r_neg_b) ? -w_core_lo : w_core_lo;
    assign w_rmd   = r_neg_a ? -w_core_hi : w_core_hi;
    assign w_raw   = r_special ? r_spec_res : (r_op[2] ? (r_op[1] ? w_rmd : w_quo) : w_mul_res);
    assign w_final = r_word ? {{HALF{w_raw[HALF-1]}}, w_raw[HALF-1:0]} : w_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_word     <= 1'b0;
            r_rd       <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            result_out <= '0;
            rd_out     <= '0;
        end else if (flush_in) begin
            r_state  <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_op       <= op_in;
                        r_word     <= word_in;
                        r_rd       <= rd_in;
                        r_neg_a    <= w_neg_a;
                        r_neg_b    <= w_neg_b;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        busy_out   <= 1'b1;
                        r_state    <= w_special ? FIN : CALC;
                    end
                end
                CALC: begin
                    if (w_core_last) r_state <= FIN;
                end
                FIN: begin
                    result_out <= w_final;
                    rd_out     <= r_rd;
                    done_out   <= 1'b1;
                    busy_out   <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
